// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS-32 control units: FSM states, opcodes and
// the multiplexer-select encodings driven onto the datapath.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_JAL       = 4'd10,
    S_JR        = 4'd11,
    S_EXEC_IMM  = 4'd12,
    S_IMM_WB    = 4'd13,
    S_UNUSED    = 4'd14,
    S_ERROR     = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_JR    = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL = 2'b11;

  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles of a memory state and flags the cycle on which the
// wait budget runs out; WAIT_EN=0 makes memory look permanently ready.
module mem_wait_timer #(
  parameter bit          WAIT_EN     = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_active_i,
  input  logic mem_ready_i,
  output logic ready_o,
  output logic expired_o
);

  localparam int CW = $clog2(MEM_TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall;

  assign ready_o = WAIT_EN ? mem_ready_i : 1'b1;
  assign stall   = wait_active_i && !ready_o;

  // Any non-stalled cycle clears, so each memory state is entered with zero.
  assign cnt_d     = stall ? cnt_q + CW'(1) : '0;
  assign expired_o = stall && (cnt_q == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing the multi-cycle MIPS-32 datapath, with memory wait
// states, timeout and illegal-opcode traps, and a retired-instruction count.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter bit          WAIT_EN     = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_wrt,
  output logic             pc_wrt_cond,
  output logic             bne,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_wrt,
  output logic             ir_wrt,
  output logic [1:0]       reg_dest,
  output logic [1:0]       mem_to_reg,
  output logic             reg_wrt,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             ori,
  output logic             lui,
  output logic [3:0]       state,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count
);

  state_e             state_q, state_d;
  logic               started_q;
  logic [5:0]         opcode_q, opcode_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready, expired;
  logic               unused_zero;

  // Branch resolution on the zero flag happens in the datapath.
  assign unused_zero = zero;

  mem_wait_timer #(
    .WAIT_EN     (WAIT_EN),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait (
    .clk           (clk),
    .reset         (reset),
    .wait_active_i (started_q && is_mem_state(state_q)),
    .mem_ready_i   (mem_ready),
    .ready_o       (ready),
    .expired_o     (expired)
  );

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    if (started_q) begin
      case (state_q)
        S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
          if (ready) begin
            case (state_q)
              S_FETCH:    state_d = S_DECODE;
              S_MEM_READ: state_d = S_MEM_WB;
              default:    state_d = S_FETCH;
            endcase
          end else if (expired) begin
            state_d   = S_ERROR;
            timeout_d = 1'b1;
          end
        end
        S_DECODE: begin
          opcode_d = opcode;
          case (opcode)
            OP_LW, OP_SW:   state_d = S_MEM_ADDR;
            OP_RTYPE:       state_d = S_EXEC_R;
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_J:           state_d = S_JUMP;
            OP_JAL:         state_d = S_JAL;
            OP_JR:          state_d = S_JR;
            OP_ORI, OP_LUI: state_d = S_EXEC_IMM;
            default: begin
              state_d   = S_ERROR;
              illegal_d = 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: state_d = (opcode_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_EXEC_R:   state_d = S_R_WB;
        S_EXEC_IMM: state_d = S_IMM_WB;
        S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_IMM_WB:
          state_d = S_FETCH;
        default:    state_d = S_ERROR;
      endcase
    end
  end

  assign cnt_d = ((state_d == S_FETCH) && (state_q != S_FETCH)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_comb begin
    pc_wrt      = 1'b0;
    pc_wrt_cond = 1'b0;
    bne         = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_wrt     = 1'b0;
    ir_wrt      = 1'b0;
    reg_dest    = RD_RT;
    mem_to_reg  = M2R_ALUOUT;
    reg_wrt     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RT;
    alu_op      = ALU_ADD;
    pc_src      = PC_ALU;
    ori         = 1'b0;
    lui         = 1'b0;
    if (started_q) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_wrt    = ready;
          pc_wrt    = ready;
        end
        S_DECODE:    alu_src_b = SRCB_IMM_SL;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEM_WB: begin
          reg_wrt    = 1'b1;
          mem_to_reg = M2R_MDR;
        end
        S_MEM_WRITE: begin
          mem_wrt = 1'b1;
          iord    = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_R_WB: begin
          reg_wrt  = 1'b1;
          reg_dest = RD_RD;
        end
        S_BRANCH: begin
          alu_src_a   = 1'b1;
          alu_op      = ALU_SUB;
          pc_wrt_cond = 1'b1;
          pc_src      = PC_ALUOUT;
          bne         = (opcode_q == OP_BNE);
        end
        S_JUMP: begin
          pc_wrt = 1'b1;
          pc_src = PC_JUMP;
        end
        S_JAL: begin
          pc_wrt     = 1'b1;
          pc_src     = PC_JUMP;
          reg_wrt    = 1'b1;
          reg_dest   = RD_RA;
          mem_to_reg = M2R_PC;
        end
        S_JR: begin
          pc_wrt = 1'b1;
          pc_src = PC_RS;
        end
        S_EXEC_IMM: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = (opcode_q == OP_ORI) ? ALU_OR : ALU_ADD;
          ori       = (opcode_q == OP_ORI);
          lui       = (opcode_q == OP_LUI);
        end
        S_IMM_WB: begin
          reg_wrt = 1'b1;
          ori     = (opcode_q == OP_ORI);
          lui     = (opcode_q == OP_LUI);
        end
        default: ;
      endcase
    end
  end

  // started_q holds the FSM in FETCH, outputs silent, for the first cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      started_q <= 1'b0;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Instruction-level reference model pushes one expected output record per
// cycle; a negedge monitor pops and compares against the DUT.
module tb_multicycle_control_unit;

  localparam int CNT_W = 4;
  localparam int MT    = 4;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, BNE = 6'b000101, JMP = 6'b000010,
                         JAL = 6'b000011, JR = 6'b001000, ORI = 6'b001101,
                         LUI = 6'b001111;

  typedef struct packed {
    logic [3:0]       st;
    logic [20:0]      ctl;
    logic             ill;
    logic             to;
    logic [CNT_W-1:0] cnt;
  } rec_t;

  logic clk, reset, zero, mem_ready;
  logic [5:0] opcode;
  logic pc_wrt, pc_wrt_cond, bne, iord, mem_read, mem_wrt, ir_wrt, reg_wrt;
  logic alu_src_a, ori, lui, illegal, timeout;
  logic [1:0] reg_dest, mem_to_reg, alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  logic [CNT_W-1:0] instr_count;

  multicycle_control_unit #(.WAIT_EN(1'b1), .MEM_TIMEOUT(MT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_wrt(pc_wrt), .pc_wrt_cond(pc_wrt_cond), .bne(bne), .iord(iord),
    .mem_read(mem_read), .mem_wrt(mem_wrt), .ir_wrt(ir_wrt), .reg_dest(reg_dest),
    .mem_to_reg(mem_to_reg), .reg_wrt(reg_wrt), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .ori(ori), .lui(lui),
    .state(state), .illegal(illegal), .timeout(timeout), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rec_t exp_q[$];
  int total = 0;
  int bad = 0;
  int m_cnt = 0;
  bit m_ill = 0;
  bit m_to = 0;

  // Control word a state should present, straight from the state table.
  function automatic logic [20:0] ctl_of(input int st, input logic [5:0] op, input logic rdy);
    logic pw, pwc, bn, io, mr, mw, irw, rw, asa, o, l;
    logic [1:0] rd, m2r, asb, aop, psrc;
    {pw, pwc, bn, io, mr, mw, irw, rw, asa, o, l} = '0;
    {rd, m2r, asb, aop, psrc} = '0;
    case (st)
      0:  begin mr = 1; asb = 2'b01; pw = rdy; irw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 2'b01; end
      5:  begin mw = 1; io = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 2'b01; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; bn = (op == BNE); end
      9:  begin pw = 1; psrc = 2'b10; end
      10: begin pw = 1; psrc = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
      11: begin pw = 1; psrc = 2'b11; end
      12: begin
        asa = 1; asb = 2'b10;
        if (op == ORI) begin aop = 2'b11; o = 1; end
        if (op == LUI) l = 1;
      end
      13: begin rw = 1; o = (op == ORI); l = (op == LUI); end
      default: ;
    endcase
    return {pw, pwc, bn, io, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, o, l};
  endfunction

  task automatic emit(input int st, input logic [5:0] drv_op, input logic rdy, input logic [5:0] lat);
    rec_t r;
    r.st  = st[3:0];
    r.ctl = ctl_of(st, lat, rdy);
    r.ill = m_ill;
    r.to  = m_to;
    r.cnt = m_cnt[CNT_W-1:0];
    opcode    = drv_op;
    mem_ready = rdy;
    zero      = 1'($urandom);
    exp_q.push_back(r);
    @(posedge clk); #1;
  endtask

  task automatic emit_r(input int st, input logic [5:0] lat);
    emit(st, 6'($urandom), 1'($urandom), lat);
  endtask

  task automatic push_zero(input logic rst_val);
    rec_t r;
    r = '0;
    reset = rst_val;
    mem_ready = 1'($urandom);
    opcode = 6'($urandom);
    exp_q.push_back(r);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    push_zero(1'b1);
    push_zero(1'b1);
    push_zero(1'b0);   // first cycle after release: outputs still silent
    m_cnt = 0; m_ill = 0; m_to = 0;
  endtask

  task automatic mem_phase(input int st, input int stall, input logic [5:0] lat, output bit ok);
    int n;
    n = (stall >= MT) ? MT : stall;
    for (int i = 0; i < n; i++) emit(st, 6'($urandom), 1'b0, lat);
    if (stall >= MT) begin
      m_to = 1; ok = 0;
    end else begin
      emit(st, 6'($urandom), 1'b1, lat); ok = 1;
    end
  endtask

  task automatic err_tail();
    emit_r(15, 6'd0);
    emit_r(15, 6'd0);
  endtask

  task automatic run_instr(input logic [5:0] op, input int fst, input int mst, output bit alive);
    bit ok;
    alive = 1;
    mem_phase(0, fst, op, ok);
    if (!ok) begin err_tail(); alive = 0; return; end
    emit(1, op, 1'($urandom), op);
    case (op)
      LW: begin emit_r(2, op); mem_phase(3, mst, op, ok); if (ok) emit_r(4, op); end
      SW: begin emit_r(2, op); mem_phase(5, mst, op, ok); end
      RT: begin emit_r(6, op); emit_r(7, op); end
      BEQ, BNE: emit_r(8, op);
      JMP: emit_r(9, op);
      JAL: emit_r(10, op);
      JR:  emit_r(11, op);
      ORI, LUI: begin emit_r(12, op); emit_r(13, op); end
      default: begin m_ill = 1; ok = 0; end
    endcase
    if (!ok) begin err_tail(); alive = 0; return; end
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      rec_t e, a;
      e = exp_q.pop_front();
      a.st  = state;
      a.ctl = {pc_wrt, pc_wrt_cond, bne, iord, mem_read, mem_wrt, ir_wrt, reg_dest,
               mem_to_reg, reg_wrt, alu_src_a, alu_src_b, alu_op, pc_src, ori, lui};
      a.ill = illegal;
      a.to  = timeout;
      a.cnt = instr_count;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle_record t=%0t got st=%0d ctl=%h ill=%b to=%b cnt=%0d want st=%0d ctl=%h ill=%b to=%b cnt=%0d",
                 $time, a.st, a.ctl, a.ill, a.to, a.cnt, e.st, e.ctl, e.ill, e.to, e.cnt);
      end
    end
  end

  initial begin
    logic [5:0] legal [10];
    bit alive;
    legal = '{LW, SW, RT, BEQ, BNE, JMP, JAL, JR, ORI, LUI};
    reset = 1'b1; opcode = '0; mem_ready = 1'b0; zero = 1'b0;
    @(posedge clk); #1;
    do_reset();

    run_instr(LW, 0, 0, alive);
    run_instr(BNE, 0, 0, alive);
    run_instr(BEQ, 1, 0, alive);
    run_instr(SW, 0, 3, alive);
    run_instr(JAL, 0, 0, alive);
    run_instr(LUI, 0, 0, alive);
    run_instr(ORI, 2, 0, alive);
    run_instr(RT, 0, 0, alive);
    run_instr(JMP, 0, 0, alive);
    run_instr(JR, 0, 0, alive);
    run_instr(LW, 3, 3, alive);

    run_instr(6'b111111, 0, 0, alive);
    do_reset();
    run_instr(LW, MT + 1, 0, alive);
    do_reset();

    // Abort a load while it is requesting memory.
    emit(0, 6'($urandom), 1'b1, LW);
    emit(1, LW, 1'b1, LW);
    emit_r(2, LW);
    emit(3, 6'($urandom), 1'b0, LW);
    do_reset();

    for (int k = 0; k < 200; k++) begin
      logic [5:0] op;
      int fst, mst;
      op  = ($urandom_range(0, 15) == 0) ? 6'($urandom) : legal[$urandom_range(0, 9)];
      fst = ($urandom_range(0, 19) == 0) ? MT : $urandom_range(0, 3);
      mst = ($urandom_range(0, 19) == 0) ? MT + 1 : $urandom_range(0, 3);
      run_instr(op, fst, mst, alive);
      if (!alive) do_reset();
    end

    @(posedge clk); #1;
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Sequential control unit for the multi-cycle MIPS-32 datapath. It replaces the single-cycle opcode decoder with a Moore FSM that runs fetch, decode, execute, memory and writeback over several cycles. The ISA subset is R-type, lw, sw, beq, bne, j, jal, jr (opcode 001000), ori and lui. Beyond the previous generation it adds a parametrised memory wait-state handshake with timeout, illegal-opcode trapping and a retired-instruction counter.

Parameters:
WAIT_EN, 1, 1: FETCH, MEM_READ and MEM_WRITE stall until mem_ready; 0: mem_ready is ignored and treated as 1
MEM_TIMEOUT, 16, maximum number of cycles a memory state waits for mem_ready before a fault (>=2)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26]; valid from DECODE onward
zero  in  1  ALU zero flag (used by datapath branch logic)
mem_ready  in  1  memory completed the current access
pc_wrt  out  1  unconditional PC write
pc_wrt_cond  out  1  conditional PC write (branch)
bne  out  1  invert branch condition
iord  out  1  0: memory address is PC; 1: memory address is ALUOut
mem_read  out  1  memory read request
mem_wrt  out  1  memory write request
ir_wrt  out  1  IR load
reg_dest  out  2  00 rt, 01 rd, 10 $31
mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
reg_wrt  out  1  register-file write
alu_src_a  out  1  0 PC, 1 rs
alu_src_b  out  2  00 rt, 01 const 4, 10 imm ext, 11 imm ext<<2
alu_op  out  2  00 add, 01 sub, 10 funct, 11 or
pc_src  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 rs
ori  out  1  zero-extend immediate
lui  out  1  immediate<<16 path
state  out  4  current state, debug
illegal  out  1  sticky: undefined opcode trapped
timeout  out  1  sticky: memory timeout
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- reset (asynchronous): state=FETCH, started=0, wait counter=0, instr_count=0, illegal=0, timeout=0, latched opcode=0. While started=0 every control output is 0. started sets on the first clk after reset release, so the first FETCH outputs appear one cycle after release. A reset mid-instruction aborts the instruction with no write asserted.
- All outputs are Moore functions of state and the opcode latched in DECODE. Any output not listed for a state is 0.
- FETCH(0): mem_read=1, alu_src_b=01, alu_op=00, pc_src=00; ir_wrt=pc_wrt=mem_ready. On mem_ready go to DECODE.
- DECODE(1): latch opcode; alu_src_b=11, alu_op=00. Next state by opcode: 100011 or 101011 -> MEM_ADDR; 000000 -> EXEC_R; 000100 or 000101 -> BRANCH; 000010 -> JUMP; 000011 -> JAL; 001000 -> JR; 001101 or 001111 -> EXEC_IMM; any other -> ERROR with illegal=1.
- MEM_ADDR(2): alu_src_a=1, alu_src_b=10. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ(3): mem_read=1, iord=1. On mem_ready go to MEM_WB.
- MEM_WB(4): reg_wrt=1, reg_dest=00, mem_to_reg=01. Then FETCH.
- MEM_WRITE(5): mem_wrt=1, iord=1. On mem_ready go to FETCH.
- EXEC_R(6): alu_src_a=1, alu_op=10. Then R_WB(7): reg_wrt=1, reg_dest=01. Then FETCH.
- BRANCH(8): alu_src_a=1, alu_op=01, pc_wrt_cond=1, pc_src=01; bne=1 for opcode 000101. Then FETCH.
- JUMP(9): pc_wrt=1, pc_src=10. JAL(10): same, plus reg_wrt=1, reg_dest=10, mem_to_reg=10. JR(11): pc_wrt=1, pc_src=11. Each then goes to FETCH.
- EXEC_IMM(12): alu_src_a=1, alu_src_b=10. ori: alu_op=11, ori=1. lui: alu_op=00, lui=1. Then IMM_WB(13): reg_wrt=1, reg_dest=00, same ori/lui as EXEC_IMM. Then FETCH.
- ERROR(15): all control outputs 0; held until reset. State 14 is unused and goes to ERROR.
- Wait counter: clears on entry to each memory state and increments each stalled cycle. If it reaches MEM_TIMEOUT-1 without mem_ready, the next state is ERROR and timeout=1. If mem_ready arrives on that same cycle, mem_ready wins.
- instr_count increments on every transition into FETCH from a non-FETCH state. It wraps modulo 2^CNT_W.

Decomposition:
- Shared package mips_ctrl_pkg holds the state encodings, opcode constants, and the alu_op, pc_src, reg_dest and mem_to_reg encodings. The single-cycle control unit also uses this package.
- Sub-module mem_wait_timer holds the wait counter, timeout compare and WAIT_EN bypass.

Test Plan:
- lw, mem_ready=1 always -> state sequence 0,1,2,3,4,0; reg_wrt only in state 4 with mem_to_reg=01; instr_count=1.
- bne opcode 000101 -> BRANCH state with pc_wrt_cond=1, bne=1, alu_op=01, pc_src=01; beq 000100 gives the same with bne=0.
- sw with mem_ready held low 3 cycles in MEM_WRITE -> mem_wrt=1 for 4 cycles, then FETCH.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> ERROR after 4 cycles, timeout=1, pc_wrt never asserted.
- opcode 111111 -> ERROR, illegal=1, sticky until async reset; reset asserted mid-cycle clears all outputs immediately.
- jal then lui -> jal: reg_dest=10, mem_to_reg=10, pc_src=10; lui: lui=1 in states 12 and 13; instr_count=2.
